// File: rtl/icache_pkg.sv
// Shared parameters, FSM state type and address-field helpers for the
// direct-mapped instruction cache.
package icache_pkg;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINES  = 2 ** IDX_W;
  localparam int unsigned WORDS  = 2 ** OFF_W;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction
endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The master modport is the cache's view; slave is the surrounding pipeline/memory.
interface icache_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0] pc_addr;
  logic              i_rd;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              i_rdy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    input  pc_addr, i_rd, flush, mem_rdata, mem_ack,
    output instr, i_rdy, mem_req, mem_addr, miss_cnt
  );

  modport slave (
    output pc_addr, i_rd, flush, mem_rdata, mem_ack,
    input  instr, i_rdy, mem_req, mem_addr, miss_cnt
  );
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one word write port,
// a tag+valid write and a global valid clear. Only valid bits are reset.
module icache_array
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid_c,
  output logic [TAG_W-1:0]  rd_tag_c,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              set_valid,
  input  logic              clr_all
);
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  // Clear is applied first so a same-edge set on a completed fill still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (clr_all) valid_q <= '0;
      if (set_valid) valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)  data_q[wr_idx][wr_off] <= wr_data;
    if (tag_we) tag_q[wr_idx] <= wr_tag;
  end

  assign rd_valid_c = valid_q[rd_idx];
  assign rd_tag_c   = tag_q[rd_idx];
  assign rd_data_c  = data_q[rd_idx][rd_off];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: zero-latency hit path, 4-word line refill
// over a req/ack memory port, flush handling and a saturating miss counter.
module icache_ctrl
  import icache_pkg::*;
(
  input logic      clk,
  input logic      rst,
  icache_if.master bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [OFF_W-1:0]  wcnt_q, wcnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              mem_req_q, mem_req_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic              rd_valid_c;
  logic [TAG_W-1:0]  rd_tag_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              hit_c;
  logic              wr_en_c, tag_we_c, set_valid_c;

  icache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (addr_idx(bus.pc_addr)),
    .rd_off     (addr_off(bus.pc_addr)),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c),
    .wr_en      (wr_en_c),
    .wr_idx     (addr_idx(fill_addr_q)),
    .wr_off     (wcnt_q),
    .wr_data    (bus.mem_rdata),
    .tag_we     (tag_we_c),
    .wr_tag     (addr_tag(fill_addr_q)),
    .set_valid  (set_valid_c),
    .clr_all    (bus.flush)
  );

  assign hit_c = rd_valid_c && (rd_tag_c == addr_tag(bus.pc_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      mem_addr_q   <= '0;
      wcnt_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      mem_addr_q   <= mem_addr_d;
      wcnt_q       <= wcnt_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    mem_addr_d   = mem_addr_q;
    wcnt_d       = wcnt_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    miss_cnt_d   = miss_cnt_q;
    wr_en_c      = 1'b0;
    tag_we_c     = 1'b0;
    set_valid_c  = 1'b0;
    bus.i_rdy    = 1'b0;
    bus.instr    = '0;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (!bus.i_rd) begin
          bus.i_rdy = 1'b1;
        end else if (hit_c) begin
          bus.i_rdy = 1'b1;
          bus.instr = rd_data_c;
        end else begin
          fill_addr_d = {addr_tag(bus.pc_addr), addr_idx(bus.pc_addr), OFF_W'(0)};
          mem_addr_d  = {addr_tag(bus.pc_addr), addr_idx(bus.pc_addr), OFF_W'(0)};
          wcnt_d      = '0;
          mem_req_d   = 1'b1;
          state_d     = FILL;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      FILL: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_ack) begin
          wr_en_c = 1'b1;
          if (wcnt_q == '1) begin
            // A flush anywhere in this fill, including this cycle, leaves the line invalid.
            tag_we_c     = 1'b1;
            set_valid_c  = !flush_pend_q && !bus.flush;
            mem_req_d    = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            wcnt_d     = wcnt_q + OFF_W'(1);
            mem_addr_d = fill_addr_q | ADDR_W'(wcnt_d);
          end
        end
      end
    endcase
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Direct-mapped instruction cache controller between the PC/IF stage and the instruction memory port. It looks up the fetch address every cycle and returns the instruction with i_rdy=1 on a hit. On a miss it drops i_rdy, and the hazard unit converts that into cache_stall. It then refills the 4-word line one word at a time over a req/ack memory handshake. Word-addressed 16-bit instruction space, matching the 16-bit datapath.

Parameters:
ADDR_W, 16, fetch/memory address width (word address)
DATA_W, 16, instruction width
IDX_W, 4, index bits (16 lines)
OFF_W, 2, word-offset bits (4 words/line); tag width = ADDR_W-IDX_W-OFF_W = 10

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
pc_addr  in  16  fetch address from IF stage
i_rd  in  1  fetch request this cycle
flush  in  1  invalidate entire cache (one-cycle pulse)
instr  out  16  fetched instruction; valid only when i_rd & i_rdy
i_rdy  out  1  instruction ready; feeds hazard unit cache_stall
mem_req  out  1  memory read request
mem_addr  out  16  memory word address, stable while mem_req=1
mem_rdata  in  16  memory read data, sampled when mem_ack=1
mem_ack  in  1  memory data valid; one ack per request
miss_cnt  out  16  saturating count of misses since reset

Behaviour:
- Address split: off=pc_addr[1:0], idx=pc_addr[5:2], tag=pc_addr[15:6].
- Storage: 16 x {valid, tag[9:0], 4 x 16-bit words}, held in flops.
- Lookup is combinational in IDLE: hit = valid[idx] & tag match.
- Hit, i_rd=1: i_rdy=1 the same cycle; instr=data[idx][off]. Zero-cycle latency.
- i_rd=0: i_rdy=1, instr=0, no state change, no memory traffic.
- Miss (IDLE, i_rd=1, !hit): i_rdy=0, instr=0.
  - Latch line base {tag,idx,2'b00} into fill_addr, word counter wcnt=0.
  - Go to FILL. miss_cnt increments, saturating at 16'hFFFF.
- FILL:
  - mem_req=1, mem_addr=fill_addr|wcnt. mem_req stays high and mem_addr stays stable until mem_ack.
  - On mem_ack: write mem_rdata into data[fill_idx][wcnt], then wcnt++.
  - mem_req may stay high back-to-back across words; mem_addr advances the cycle after each ack.
  - On ack of word 3: write tag[fill_idx]; set valid[fill_idx]=1 unless a flush occurred during this fill. Then go to IDLE.
  - i_rdy=0 throughout FILL, including the cycle of the last ack.
- After fill: IDLE re-evaluates the current pc_addr. If the PC changed (branch redirect during the stall), the new address may miss again and starts a new fill.
- mem_ack while mem_req=0 is ignored.
- flush:
  - In IDLE: clears all valid bits at the clock edge. A lookup in the same cycle still uses pre-flush valid bits.
  - In FILL: clears all valid bits and sets flush_pend. The fill runs to completion (no abandoned memory request), but the refilled line is left invalid. flush_pend clears on return to IDLE.
- States: IDLE, FILL. Encoded in the package.
- Reset (async) sets:
  - state=IDLE, all valid=0, flush_pend=0, wcnt=0, mem_req=0, mem_addr=0, miss_cnt=0
  - outputs: i_rdy=1 (since i_rd is qualified), instr=0
- Data/tag arrays are not reset; only valid bits are.

Decomposition:
- Package icache_pkg: ADDR_W, DATA_W, IDX_W, OFF_W, TAG_W; state enum {IDLE, FILL}; address-field extract functions.
- Sub-module icache_array: valid/tag/data storage with one combinational read port (idx, off) and one write port (word write, tag+valid write, global valid clear).
- icache_ctrl holds the FSM, fill counter, memory handshake and miss counter.

Test Plan:
- Reset with i_rd=1, pc=0x0000 -> i_rdy=0 the cycle after reset releases. One mem_req at 0x0000 follows. miss_cnt=1.
- Cold fill, memory acks 2 cycles after each req, data 0x1000..0x1003 -> mem_addr sequence 0x0000, 0x0001, 0x0002, 0x0003. i_rdy returns to 1 one cycle after the 4th ack with instr=0x1000. pc=0x0002 then hits with instr=0x1002 and zero latency.
- Conflict miss: after line 0x0000 is filled, fetch 0x0040 (same idx 0, tag 1) -> miss, refill at 0x0040..0x0043, miss_cnt=2. Re-fetch 0x0000 -> miss again, miss_cnt=3.
- flush asserted on the 2nd ack of a fill -> all 4 words still requested. Next lookup of the same address misses and refills; miss_cnt increments.
- i_rd=0 for 10 cycles with an uncached pc -> i_rdy=1, mem_req=0 throughout, miss_cnt unchanged.
- Spurious mem_ack in IDLE, and async rst asserted mid-FILL -> no array write, mem_req drops immediately, all valid=0. A previously cached address misses afterward.
